// File: rtl/led_blink_scheduler_if.sv
// Request/status bundle between two blink-code requesters and the shared
// LED scheduler. The master side drives requests; the slave side is the
// scheduler.
interface led_blink_scheduler_if #(
  parameter int CNT_W = 4
);
  logic             req0_valid;
  logic [CNT_W-1:0] req0_count;
  logic             req0_ready;
  logic             req1_valid;
  logic [CNT_W-1:0] req1_count;
  logic             req1_ready;
  logic             busy;
  logic             grant;
  logic             done;
  logic             led;

  modport master (
    output req0_valid, req0_count, req1_valid, req1_count,
    input  req0_ready, req1_ready, busy, grant, done, led
  );

  modport slave (
    input  req0_valid, req0_count, req1_valid, req1_count,
    output req0_ready, req1_ready, busy, grant, done, led
  );
endinterface

// File: rtl/led_blink_scheduler.sv
// Shares one status LED between two requesters. Each accepted request plays
// N blinks (ON/OFF phases) followed by a dark gap. Requests are arbitrated
// round-robin in IDLE only; phase timing comes from an internal prescaler.
module led_blink_scheduler #(
  parameter int TICK_DIV  = 6000000,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int GAP_TICKS = 4,
  parameter int CNT_W     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  led_blink_scheduler_if.slave  bus
);

  localparam int PS_W   = $clog2(TICK_DIV);
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_GAP
  } state_t;

  state_t           state, next_state;
  logic [PS_W-1:0]  prescaler;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] remaining;
  logic             last_served;
  logic             grant_q;
  logic             busy_q;
  logic             done_q;
  logic             led_q;

  logic             pick;
  logic             ready0;
  logic             ready1;
  logic             handshake;
  logic [CNT_W-1:0] hs_count;
  logic             tick;
  logic             seq_done;

  // Round-robin arbitration: with a tie (or nobody asking) the requester
  // that was not served last gets READY; a lone requester always wins.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    pick = ~last_served;
    if (bus.req0_valid && !bus.req1_valid) begin
      pick = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      pick = 1'b1;
    end
    ready0    = (state == ST_IDLE) && !pick;
    ready1    = (state == ST_IDLE) &&  pick;
    handshake = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);
    hs_count  = pick ? bus.req1_count : bus.req0_count;
  end

  assign tick = (state != ST_IDLE) && (prescaler == PS_LAST);

  // Next-state logic: phases advance only on the tick that ends them.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (handshake && (hs_count != '0)) next_state = ST_ON;
      ST_ON: begin
        if (tick && (phase == ON_LAST)) begin
          next_state = (remaining > CNT_W'(1)) ? ST_OFF : ST_GAP;
        end
      end
      ST_OFF:  if (tick && (phase == OFF_LAST)) next_state = ST_ON;
      ST_GAP:  if (tick && (phase == GAP_LAST)) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    seq_done = (state == ST_GAP) && (next_state == ST_IDLE);
  end

  // State register; reset aborts any sequence on the spot.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the values from before this edge.
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Timing counters, blink bookkeeping and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prescaler   <= '0;
      phase       <= '0;
      remaining   <= '0;
      last_served <= 1'b1;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      busy_q <= (next_state != ST_IDLE);
      led_q  <= (next_state == ST_ON);
      done_q <= seq_done || (handshake && (hs_count == '0));

      if (handshake) begin
        grant_q     <= pick;
        last_served <= pick;
        remaining   <= hs_count;
        prescaler   <= '0;
        phase       <= '0;
      end else if (state != ST_IDLE) begin
        prescaler <= tick ? '0 : prescaler + PS_W'(1);
        if (next_state != state) begin
          phase <= '0;
        end else if (tick) begin
          phase <= phase + PH_W'(1);
        end
        if ((state == ST_ON) && (next_state == ST_OFF)) begin
          remaining <= remaining - CNT_W'(1);
        end
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.busy       = busy_q;
  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.led        = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with a short tick so whole blink
// sequences fit in a few dozen cycles.
module tb_led_blink_scheduler;

  localparam int TICK_DIV  = 4;
  localparam int ON_TICKS  = 1;
  localparam int OFF_TICKS = 1;
  localparam int GAP_TICKS = 2;
  localparam int CNT_W     = 4;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  led_blink_scheduler_if #(.CNT_W(CNT_W)) bus ();

  led_blink_scheduler #(
    .TICK_DIV (TICK_DIV),
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS),
    .GAP_TICKS(GAP_TICKS),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_count = '0;
    bus.req1_valid = 1'b0;
    bus.req1_count = '0;
    repeat (3) step();
    RST = 1'b0;
    #1;
    n_checks++; if (bus.led !== 1'b0) begin n_fail++; $display("FAIL reset_led got %b want 0", bus.led); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %b want 0", bus.grant); end
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready0 got %b want 1", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got %b want 0", bus.req1_ready); end
  endtask

  // Count of 3 from requester 0: handshake in cycle k, then a fixed LED
  // pattern until DONE in k+29.
  task automatic test_single_count3();
    logic exp_led, exp_busy, exp_done;
    bus.req0_valid = 1'b1;
    bus.req0_count = 4'd3;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready0 got %b want 1", bus.req0_ready); end
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 1) begin
        bus.req0_valid = 1'b0;
        bus.req0_count = '0;
        n_checks++; if (bus.grant !== 1'b0) begin n_fail++; $display("FAIL single_grant got %b want 0", bus.grant); end
      end
      exp_led  = (i >= 1 && i <= 4) || (i >= 9 && i <= 12) || (i >= 17 && i <= 20);
      exp_busy = (i >= 1 && i <= 28);
      exp_done = (i == 29);
      n_checks++; if (bus.led !== exp_led) begin n_fail++; $display("FAIL single_led k+%0d got %b want %b", i, bus.led, exp_led); end
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL single_busy k+%0d got %b want %b", i, bus.busy, exp_busy); end
      n_checks++; if (bus.done !== exp_done) begin n_fail++; $display("FAIL single_done k+%0d got %b want %b", i, bus.done, exp_done); end
    end
  endtask

  // Both request right after reset: req0 wins, req1 is taken in the DONE
  // cycle of req0's sequence and plays two blinks (8 lit cycles).
  task automatic test_back_to_back();
    int lit;
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_count = 4'd1;
    bus.req1_valid = 1'b1;
    bus.req1_count = 4'd2;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got %b want 1", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready1 got %b want 0", bus.req1_ready); end
    step();
    bus.req0_valid = 1'b0;
    n_checks++; if (bus.grant !== 1'b0) begin n_fail++; $display("FAIL b2b_grant_first got %b want 0", bus.grant); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready1_busy got %b want 0", bus.req1_ready); end
    repeat (12) step();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_first got %b want 1", bus.done); end
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1_done got %b want 1", bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    n_checks++; if (bus.grant !== 1'b1) begin n_fail++; $display("FAIL b2b_grant_second got %b want 1", bus.grant); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_second got %b want 1", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_cleared got %b want 0", bus.done); end
    lit = (bus.led === 1'b1) ? 1 : 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (bus.led === 1'b1) lit++;
      if (j < 20) begin
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_early j=%0d got %b want 0", j, bus.done); end
      end
    end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_second got %b want 1", bus.done); end
    n_checks++; if (lit !== 8) begin n_fail++; $display("FAIL b2b_lit_cycles got %0d want 8", lit); end
  endtask

  // Zero-length request: accepted, DONE next cycle, LED and BUSY stay low.
  task automatic test_zero_count();
    bus.req1_valid = 1'b1;
    bus.req1_count = 4'd0;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready1 got %b want 1", bus.req1_ready); end
    step();
    bus.req1_valid = 1'b0;
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.led !== 1'b0) begin n_fail++; $display("FAIL zero_led got %b want 0", bus.led); end
    n_checks++; if (bus.grant !== 1'b1) begin n_fail++; $display("FAIL zero_grant got %b want 1", bus.grant); end
    step();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_clear got %b want 0", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got %b want 0", bus.busy); end
  endtask

  // Reset in the second ON phase of a count=3 sequence.
  task automatic test_reset_mid();
    bus.req0_valid = 1'b1;
    bus.req0_count = 4'd3;
    step();
    bus.req0_valid = 1'b0;
    repeat (9) step();
    n_checks++; if (bus.led !== 1'b1) begin n_fail++; $display("FAIL mid_led_before got %b want 1", bus.led); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    n_checks++; if (bus.led !== 1'b0) begin n_fail++; $display("FAIL mid_led_after got %b want 0", bus.led); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_after got %b want 0", bus.busy); end
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready0 got %b want 1", bus.req0_ready); end
    n_checks++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready1 got %b want 0", bus.req1_ready); end
    for (int j = 0; j < 30; j++) begin
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done j=%0d got %b want 0", j, bus.done); end
      step();
    end
  endtask

  // Both requesters held valid with count=1: grants must alternate.
  task automatic test_alternate();
    logic exp_grant [4];
    exp_grant[0] = 1'b0;
    exp_grant[1] = 1'b1;
    exp_grant[2] = 1'b0;
    exp_grant[3] = 1'b1;
    RST = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_count = 4'd1;
    bus.req1_valid = 1'b1;
    bus.req1_count = 4'd1;
    for (int g = 0; g < 4; g++) begin
      step();
      n_checks++; if (bus.grant !== exp_grant[g]) begin n_fail++; $display("FAIL alt_grant%0d got %b want %b", g, bus.grant, exp_grant[g]); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL alt_busy%0d got %b want 1", g, bus.busy); end
      repeat (12) step();
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL alt_done%0d got %b want 1", g, bus.done); end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_count = '0;
    bus.req1_valid = 1'b0;
    bus.req1_count = '0;
    test_reset();
    test_single_count3();
    test_back_to_back();
    test_zero_count();
    test_reset_mid();
    test_alternate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
